// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the core bus arbiter.
// Contents: Avalon-MM request/response structs, owner tags for the response
// FIFO, and the arbiter FSM state encoding.
package core_bus_arbiter_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;
  } avalon_resp_t;

  localparam logic ARB_TAG_IBUS = 1'b0;
  localparam logic ARB_TAG_DBUS = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StOwnI,
    StOwnD
  } arb_state_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// Owner-tag FIFO: records which master issued each accepted read so that the
// in-order read responses can be routed back.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write a tag; ignored while full
//   pop,  pop_data  consume the head; ignored while empty, pop_data = 0 when empty
//   full, empty     registered occupancy flags
//   count           number of stored tags
module arb_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 pop_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-master (ibus, dbus) to one-slave Avalon-MM arbiter.
// A winner is granted with zero latency in IDLE; if the slave stalls, the
// grant is held (OWN_I / OWN_D) until the transfer is accepted. Read owners
// are queued in a tag FIFO and readdatavalid is steered to the head owner.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ibus_avalon_req/resp     instruction-fetch master side
//   dbus_avalon_req/resp     load/store master side
//   mem_avalon_req/resp      shared slave side
// Build option: define CORE_BUS_ARB_ROUND_ROBIN_EN for round-robin contention
// resolution; otherwise dbus always wins.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  ibus_avalon_req,
  output avalon_resp_t ibus_avalon_resp,
  input  avalon_req_t  dbus_avalon_req,
  output avalon_resp_t dbus_avalon_resp,
  output avalon_req_t  mem_avalon_req,
  input  avalon_resp_t mem_avalon_resp
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e      state_q, state_d;
  logic            i_req, d_req, i_ok, d_ok;
  logic            gnt_valid, gnt_tag;
  logic            accept, push, pop;
  logic            head_tag, tag_full, tag_empty;
  logic [CntW-1:0] tag_count;

  assign i_req = ibus_avalon_req.read | ibus_avalon_req.write;
  assign d_req = dbus_avalon_req.read | dbus_avalon_req.write;
  // Reads are blocked while the FIFO is full (registered flag); writes pass.
  assign i_ok  = i_req & ~(ibus_avalon_req.read & tag_full);
  assign d_ok  = d_req & ~(dbus_avalon_req.read & tag_full);

`ifdef CORE_BUS_ARB_ROUND_ROBIN_EN
  // Holds the tag of the master granted most recently.
  logic rr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= ARB_TAG_IBUS;
    end else if (accept) begin
      rr_q <= gnt_tag;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_valid = 1'b0;
    gnt_tag   = ARB_TAG_IBUS;
    unique case (state_q)
      StIdle: begin
        if (i_ok && d_ok) begin
          gnt_valid = 1'b1;
`ifdef CORE_BUS_ARB_ROUND_ROBIN_EN
          gnt_tag   = ~rr_q;
`else
          gnt_tag   = ARB_TAG_DBUS;
`endif
        end else if (d_ok) begin
          gnt_valid = 1'b1;
          gnt_tag   = ARB_TAG_DBUS;
        end else if (i_ok) begin
          gnt_valid = 1'b1;
          gnt_tag   = ARB_TAG_IBUS;
        end
        if (gnt_valid && mem_avalon_resp.waitrequest) begin
          state_d = (gnt_tag == ARB_TAG_DBUS) ? StOwnD : StOwnI;
        end
      end
      StOwnI: begin
        gnt_tag = ARB_TAG_IBUS;
        if (!i_ok) begin
          state_d = StIdle;
        end else begin
          gnt_valid = 1'b1;
          if (!mem_avalon_resp.waitrequest) state_d = StIdle;
        end
      end
      StOwnD: begin
        gnt_tag = ARB_TAG_DBUS;
        if (!d_ok) begin
          state_d = StIdle;
        end else begin
          gnt_valid = 1'b1;
          if (!mem_avalon_resp.waitrequest) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Nothing is granted while reset is held so the slave sees an idle bus.
    if (rst) gnt_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign accept = gnt_valid & ~mem_avalon_resp.waitrequest;
  assign push   = accept & mem_avalon_req.read;
  assign pop    = mem_avalon_resp.readdatavalid & ~tag_empty & ~rst;

  always_comb begin
    mem_avalon_req = '0;
    if (gnt_valid) begin
      mem_avalon_req = (gnt_tag == ARB_TAG_DBUS) ? dbus_avalon_req : ibus_avalon_req;
    end

    ibus_avalon_resp = '0;
    dbus_avalon_resp = '0;
    ibus_avalon_resp.waitrequest = 1'b1;
    dbus_avalon_resp.waitrequest = 1'b1;
    if (gnt_valid) begin
      if (gnt_tag == ARB_TAG_DBUS) dbus_avalon_resp.waitrequest = mem_avalon_resp.waitrequest;
      else                         ibus_avalon_resp.waitrequest = mem_avalon_resp.waitrequest;
    end

    // Data is broadcast only for a response that has an owner.
    if (pop) begin
      ibus_avalon_resp.readdata      = mem_avalon_resp.readdata;
      dbus_avalon_resp.readdata      = mem_avalon_resp.readdata;
      ibus_avalon_resp.readdatavalid = (head_tag == ARB_TAG_IBUS);
      dbus_avalon_resp.readdatavalid = (head_tag == ARB_TAG_DBUS);
    end
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (gnt_tag),
    .pop       (pop),
    .pop_data  (head_tag),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  a_ibus_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ibus_avalon_req.read && ibus_avalon_req.write));
  a_dbus_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(dbus_avalon_req.read && dbus_avalon_req.write));
  a_rdv_has_owner: assert property (@(posedge clk) disable iff (rst)
    mem_avalon_resp.readdatavalid |-> !tag_empty);
  a_own_i_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == StOwnI) |-> i_req);
  a_own_d_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == StOwnD) |-> d_req);
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    tag_count <= CntW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  avalon_req_t  ireq, dreq, mreq;
  avalon_resp_t iresp, dresp, mresp;
  int           n_cmp = 0;
  int           n_err = 0;

  core_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ibus_avalon_req  (ireq),
    .ibus_avalon_resp (iresp),
    .dbus_avalon_req  (dreq),
    .dbus_avalon_resp (dresp),
    .mem_avalon_req   (mreq),
    .mem_avalon_resp  (mresp)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ireq  = '0;
    dreq  = '0;
    mresp = '0;
  endtask

  task automatic rd(output avalon_req_t r, input logic [31:0] a);
    r = '{read: 1'b1, write: 1'b0, address: a, writedata: 32'h0, byteenable: 4'hf};
  endtask

  task automatic wr(output avalon_req_t r, input logic [31:0] a);
    r = '{read: 1'b0, write: 1'b1, address: a, writedata: 32'hCAFE0000 | a, byteenable: 4'hf};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd(ireq, 32'h100);
    wr(dreq, 32'h200);
    mresp = '{readdata: 32'h55, waitrequest: 1'b0, readdatavalid: 1'b1};
    next_cycle();
    next_cycle();
    n_cmp++; if (mreq !== '0) begin
      n_err++; $display("FAIL reset_mem_req: got %h expected 0", mreq); end
    n_cmp++; if (iresp !== '{readdata: 32'h0, waitrequest: 1'b1, readdatavalid: 1'b0}) begin
      n_err++; $display("FAIL reset_ibus_resp: got %h expected waitrequest only", iresp); end
    n_cmp++; if (dresp !== '{readdata: 32'h0, waitrequest: 1'b1, readdatavalid: 1'b0}) begin
      n_err++; $display("FAIL reset_dbus_resp: got %h expected waitrequest only", dresp); end
    n_cmp++; if (dut.tag_count !== 3'd0) begin
      n_err++; $display("FAIL reset_fifo_empty: got %0d expected 0", dut.tag_count); end
    quiet();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_read();
    rd(ireq, 32'h100);
    #1;
    n_cmp++; if (!(mreq.read === 1'b1 && mreq.address === 32'h100)) begin
      n_err++; $display("FAIL single_fwd: got rd=%b addr=%h expected 1/100", mreq.read, mreq.address); end
    n_cmp++; if (iresp.waitrequest !== 1'b0 || dresp.waitrequest !== 1'b1) begin
      n_err++; $display("FAIL single_wait: got i=%b d=%b expected 0/1",
                        iresp.waitrequest, dresp.waitrequest); end
    next_cycle();
    ireq = '0;
    next_cycle();
    mresp = '{readdata: 32'hDEADBEEF, waitrequest: 1'b0, readdatavalid: 1'b1};
    #1;
    n_cmp++; if (iresp.readdatavalid !== 1'b1 || iresp.readdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_resp: got v=%b d=%h expected 1/deadbeef",
                        iresp.readdatavalid, iresp.readdata); end
    n_cmp++; if (dresp.readdatavalid !== 1'b0) begin
      n_err++; $display("FAIL single_dbus_quiet: got %b expected 0", dresp.readdatavalid); end
    next_cycle();
    quiet();
  endtask

  task automatic test_contention();
    rd(ireq, 32'h104);
    wr(dreq, 32'h2000);
    #1;
    n_cmp++; if (!(mreq.write === 1'b1 && mreq.address === 32'h2000 && mreq.read === 1'b0)) begin
      n_err++; $display("FAIL cont_first: got w=%b addr=%h expected dbus write 2000",
                        mreq.write, mreq.address); end
    n_cmp++; if (dresp.waitrequest !== 1'b0 || iresp.waitrequest !== 1'b1) begin
      n_err++; $display("FAIL cont_first_wait: got d=%b i=%b expected 0/1",
                        dresp.waitrequest, iresp.waitrequest); end
    next_cycle();
    dreq = '0;
    #1;
    n_cmp++; if (!(mreq.read === 1'b1 && mreq.address === 32'h104 && iresp.waitrequest === 1'b0)) begin
      n_err++; $display("FAIL cont_second: got rd=%b addr=%h wr=%b expected ibus read 104",
                        mreq.read, mreq.address, iresp.waitrequest); end
    next_cycle();
    ireq = '0;
    mresp = '{readdata: 32'h11, waitrequest: 1'b0, readdatavalid: 1'b1};
    #1;
    n_cmp++; if (iresp.readdatavalid !== 1'b1 || dresp.readdatavalid !== 1'b0) begin
      n_err++; $display("FAIL cont_resp: got i=%b d=%b expected 1/0",
                        iresp.readdatavalid, dresp.readdatavalid); end
    next_cycle();
    quiet();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr [4];
`ifdef CORE_BUS_ARB_ROUND_ROBIN_EN
    exp_addr = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
`else
    exp_addr = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
`endif
    wr(ireq, 32'h1000);
    wr(dreq, 32'h2000);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (mreq.address !== exp_addr[k] || mreq.write !== 1'b1) begin
        n_err++; $display("FAIL b2b_grant_%0d: got addr=%h expected %h", k, mreq.address, exp_addr[k]); end
      n_cmp++; if (dresp.waitrequest !== (exp_addr[k] != 32'h2000) ||
                   iresp.waitrequest !== (exp_addr[k] != 32'h1000)) begin
        n_err++; $display("FAIL b2b_wait_%0d: got d=%b i=%b", k, dresp.waitrequest, iresp.waitrequest); end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_hold();
    rd(ireq, 32'h100);
    rd(dreq, 32'h3000);
    mresp.waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mresp.waitrequest = 1'b0;
      #1;
      n_cmp++; if (mreq.address !== 32'h3000 || mreq.read !== 1'b1) begin
        n_err++; $display("FAIL hold_addr_%0d: got addr=%h rd=%b expected 3000/1", k, mreq.address, mreq.read); end
      n_cmp++; if (iresp.waitrequest !== 1'b1 || dresp.waitrequest !== (k < 3)) begin
        n_err++; $display("FAIL hold_wait_%0d: got i=%b d=%b", k, iresp.waitrequest, dresp.waitrequest); end
      if (k > 0) begin
        n_cmp++; if (dut.state_q !== StOwnD) begin
          n_err++; $display("FAIL hold_state_%0d: got %0d expected OWN_D", k, dut.state_q); end
      end
      next_cycle();
    end
    dreq = '0;
    #1;
    n_cmp++; if (mreq.address !== 32'h100 || iresp.waitrequest !== 1'b0) begin
      n_err++; $display("FAIL hold_ibus_next: got addr=%h wr=%b expected 100/0", mreq.address, iresp.waitrequest); end
    next_cycle();
    ireq = '0;
    mresp = '{readdata: 32'h33, waitrequest: 1'b0, readdatavalid: 1'b1};
    #1;
    n_cmp++; if (dresp.readdatavalid !== 1'b1 || iresp.readdatavalid !== 1'b0 || dresp.readdata !== 32'h33) begin
      n_err++; $display("FAIL hold_resp_d: got d=%b i=%b data=%h", dresp.readdatavalid,
                        iresp.readdatavalid, dresp.readdata); end
    next_cycle();
    mresp.readdata = 32'h44;
    #1;
    n_cmp++; if (iresp.readdatavalid !== 1'b1 || dresp.readdatavalid !== 1'b0) begin
      n_err++; $display("FAIL hold_resp_i: got i=%b d=%b expected 1/0", iresp.readdatavalid, dresp.readdatavalid); end
    next_cycle();
    quiet();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      rd(ireq, 32'h400 + 32'(4 * k));
      #1;
      n_cmp++; if (iresp.waitrequest !== 1'b0 || mreq.read !== 1'b1) begin
        n_err++; $display("FAIL full_fill_%0d: got wr=%b rd=%b expected 0/1", k, iresp.waitrequest, mreq.read); end
      next_cycle();
    end
    rd(ireq, 32'h500);
    wr(dreq, 32'h2004);
    #1;
    n_cmp++; if (mreq.read !== 1'b0 || mreq.write !== 1'b1 || mreq.address !== 32'h2004) begin
      n_err++; $display("FAIL full_write_pass: got rd=%b w=%b addr=%h expected 0/1/2004",
                        mreq.read, mreq.write, mreq.address); end
    n_cmp++; if (iresp.waitrequest !== 1'b1 || dresp.waitrequest !== 1'b0) begin
      n_err++; $display("FAIL full_wait: got i=%b d=%b expected 1/0", iresp.waitrequest, dresp.waitrequest); end
    next_cycle();
    dreq = '0;
    mresp = '{readdata: 32'hA0, waitrequest: 1'b0, readdatavalid: 1'b1};
    #1;
    n_cmp++; if (mreq.read !== 1'b0 || iresp.waitrequest !== 1'b1 || iresp.readdatavalid !== 1'b1) begin
      n_err++; $display("FAIL full_pop_cycle: got rd=%b wr=%b v=%b expected 0/1/1",
                        mreq.read, iresp.waitrequest, iresp.readdatavalid); end
    next_cycle();
    mresp = '0;
    #1;
    n_cmp++; if (mreq.read !== 1'b1 || mreq.address !== 32'h500 || iresp.waitrequest !== 1'b0) begin
      n_err++; $display("FAIL full_freed: got rd=%b addr=%h wr=%b expected 1/500/0",
                        mreq.read, mreq.address, iresp.waitrequest); end
    next_cycle();
    ireq = '0;
    for (int k = 0; k < 4; k++) begin
      mresp = '{readdata: 32'hA1 + 32'(k), waitrequest: 1'b0, readdatavalid: 1'b1};
      #1;
      n_cmp++; if (iresp.readdatavalid !== 1'b1 || dresp.readdatavalid !== 1'b0) begin
        n_err++; $display("FAIL full_drain_%0d: got i=%b d=%b expected 1/0", k,
                          iresp.readdatavalid, dresp.readdatavalid); end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_interleave_reset();
    logic [2:0] exp_i;
    logic [2:0] exp_d;
    exp_i = 3'b101;
    exp_d = 3'b010;
    rd(ireq, 32'h10);
    next_cycle();
    ireq = '0;
    rd(dreq, 32'h20);
    next_cycle();
    dreq = '0;
    rd(ireq, 32'h30);
    next_cycle();
    ireq = '0;
    for (int k = 0; k < 3; k++) begin
      mresp = '{readdata: 32'(k + 1), waitrequest: 1'b0, readdatavalid: 1'b1};
      #1;
      n_cmp++; if (iresp.readdatavalid !== exp_i[2-k] || dresp.readdatavalid !== exp_d[2-k] ||
                   iresp.readdata !== 32'(k + 1)) begin
        n_err++; $display("FAIL inter_resp_%0d: got i=%b d=%b data=%h", k, iresp.readdatavalid,
                          dresp.readdatavalid, iresp.readdata); end
      next_cycle();
    end
    mresp = '0;
    rd(ireq, 32'h40);
    next_cycle();
    ireq = '0;
    rst = 1'b1;
    next_cycle();
    mresp = '{readdata: 32'hBAD, waitrequest: 1'b0, readdatavalid: 1'b1};
    #1;
    n_cmp++; if (iresp.readdatavalid !== 1'b0 || dresp.readdatavalid !== 1'b0) begin
      n_err++; $display("FAIL late_rdv_dropped: got i=%b d=%b expected 0/0",
                        iresp.readdatavalid, dresp.readdatavalid); end
    n_cmp++; if (dut.tag_count !== 3'd0) begin
      n_err++; $display("FAIL reset_clears_fifo: got %0d expected 0", dut.tag_count); end
    next_cycle();
    quiet();
    rst = 1'b0;
    next_cycle();
    rd(dreq, 32'h50);
    next_cycle();
    dreq = '0;
    mresp = '{readdata: 32'h5, waitrequest: 1'b0, readdatavalid: 1'b1};
    #1;
    n_cmp++; if (dresp.readdatavalid !== 1'b1 || iresp.readdatavalid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_route: got d=%b i=%b expected 1/0",
                        dresp.readdatavalid, iresp.readdatavalid); end
    next_cycle();
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_hold();
    test_full();
    test_interleave_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
